// File: rtl/cpu_pkg.sv
// Shared CPU definitions: widths, halt encoding, fetch FSM states, and the
// condition/flag encodings used by the control FSM.
package cpu_pkg;

  localparam int CPU_ADDR_W = 10;
  localparam int CPU_DATA_W = 16;

  // An all-zero word stops the machine.
  localparam logic [CPU_DATA_W-1:0] HALT_INSTR = 16'h0000;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_WAIT   = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_e;

  // Captured fetch result: word plus its one-cycle valid strobe.
  typedef struct packed {
    logic [CPU_DATA_W-1:0] word;
    logic                  vld;
  } fetch_rsp_t;

  // Branch condition codes and ALU flags, consumed by the control FSM.
  typedef enum logic [2:0] {
    COND_AL = 3'd0,
    COND_EQ = 3'd1,
    COND_NE = 3'd2,
    COND_CS = 3'd3,
    COND_CC = 3'd4,
    COND_MI = 3'd5,
    COND_PL = 3'd6,
    COND_NV = 3'd7
  } cond_e;

  typedef struct packed {
    logic z;
    logic c;
    logic n;
    logic v;
  } flags_t;

endpackage

// File: rtl/pc_counter.sv
// Program counter: reset value, load, and increment with natural wrap.
module pc_counter #(
  parameter int                ADDR_W   = 10,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inc,
  input  logic              ld,
  input  logic [ADDR_W-1:0] ld_val,
  output logic [ADDR_W-1:0] pc
);

  // Load has priority; increment wraps from all-ones to zero silently.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)   pc <= RESET_PC;
    else if (ld)  pc <= ld_val;
    else if (inc) pc <= pc + ADDR_W'(1);
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, steers memory port A's address, captures
// fetched words and latches halt / protocol-fault flags.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = CPU_ADDR_W,
  parameter int                DATA_W   = CPU_DATA_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pc_en,
  input  logic              pc_ld,
  input  logic              pc_sel,
  input  logic [DATA_W-1:0] target,
  input  logic [DATA_W-1:0] data_addr,
  input  logic [DATA_W-1:0] mem_q,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [ADDR_W-1:0] pc_ins,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  output logic              halted,
  output logic              err
);

  fetch_state_e state_q, state_d;

  logic pc_inc, pc_load, err_set, cap, halt_set;
  logic [DATA_W-1:0] instr_q;
  logic              vld_q;

  // Upper data-address bits are outside the memory map and deliberately dropped.
  logic unused_addr_hi;
  assign unused_addr_hi = ^data_addr[DATA_W-1:ADDR_W];

  pc_counter #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk    (clk),
    .reset  (reset),
    .inc    (pc_inc),
    .ld     (pc_load),
    .ld_val (target[ADDR_W-1:0]),
    .pc     (pc_ins)
  );

  assign mem_addr    = pc_sel ? pc_ins : data_addr[ADDR_W-1:0];
  assign instr       = instr_q;
  assign instr_valid = vld_q;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_RUN;
    else        state_q <= state_d;
  end

  // Next state and per-cycle control strobes.
  always_comb begin
    state_d  = state_q;
    pc_inc   = 1'b0;
    pc_load  = 1'b0;
    err_set  = 1'b0;
    cap      = 1'b0;
    halt_set = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (pc_en) begin
          if (pc_ld) begin
            // Low bits still load even when the target is out of range.
            pc_load = 1'b1;
            err_set = |target[DATA_W-1:ADDR_W];
          end else if (pc_sel) begin
            pc_inc  = 1'b1;
            state_d = ST_WAIT;
          end else begin
            // Fetch requested while memory is steered to the data address.
            err_set = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        cap     = 1'b1;
        err_set = pc_en;
        if (mem_q == DATA_W'(HALT_INSTR)) begin
          halt_set = 1'b1;
          state_d  = ST_HALTED;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_HALTED: ;
      default: state_d = ST_RUN;
    endcase
  end

  // Instruction register and its one-cycle valid pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_q <= '0;
      vld_q   <= 1'b0;
    end else begin
      vld_q <= cap;
      if (cap) instr_q <= mem_q;
    end
  end

  // Sticky halt and fault flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      halted <= 1'b0;
      err    <= 1'b0;
    end else begin
      if (halt_set) halted <= 1'b1;
      if (err_set)  err    <= 1'b1;
    end
  end

endmodule
